// File: rtl/muldiv4_seq_pkg.sv
// Shared constants for the sequential multiplier/divider: FSM state encoding
// and opcode values.
package muldiv4_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv4_seq_addsub_core.sv
// Combinational W-bit adder/subtractor shared by both arithmetic modes.
// Ports:
//   x, y : operands
//   sub  : 0 = x + y, 1 = x - y
//   r    : result modulo 2^W
//   co   : carry out for add, no-borrow flag for subtract
module addsub_core #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         sub,
  output logic [W-1:0] r,
  output logic         co
);

  logic [W:0] sum;

  // Subtraction as x + ~y + 1; the top bit is then the no-borrow flag.
  always_comb begin
    sum = {1'b0, x} + {1'b0, (sub ? ~y : y)} + (W+1)'(sub);
    r   = sum[W-1:0];
    co  = sum[W];
  end

endmodule

// File: rtl/muldiv4_seq.sv
// Sequential unsigned multiplier/divider: shift-add multiply or restoring
// divide over W iterations on one shared adder/subtractor.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start, op     : operation request (sampled when not busy), 0=mul 1=div
//   a, b          : multiplicand/dividend, multiplier/divisor
//   busy          : high while iterating
//   done          : one-cycle pulse when result is valid
//   result        : product, or {remainder, quotient}
//   div0          : divide by zero flag, held with result
module muldiv4_seq
  import muldiv4_seq_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           div0
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  state_t           state, state_n;
  logic [W-1:0]     acc, acc_n, q, q_n, m, m_n;
  logic             opr, opr_n;
  logic [CW-1:0]    count, count_n;
  logic [2*W-1:0]   result_n;
  logic             div0_n, busy_n, done_n;

  logic [W-1:0]     as_x, as_r;
  logic             as_co;

  // Divide feeds the shifted partial remainder; multiply feeds acc directly.
  assign as_x = (opr == OP_DIV) ? {acc[W-2:0], q[W-1]} : acc;

  addsub_core #(.W(W)) u_addsub (
    .x   (as_x),
    .y   (m),
    .sub (opr),
    .r   (as_r),
    .co  (as_co)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      opr    <= 1'b0;
      count  <= '0;
      result <= '0;
      div0   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      acc    <= acc_n;
      q      <= q_n;
      m      <= m_n;
      opr    <= opr_n;
      count  <= count_n;
      result <= result_n;
      div0   <= div0_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

  // Next-state, iteration step and output staging.
  always_comb begin
    logic c, qb;
    logic [W-1:0] s;
    state_n  = state;
    acc_n    = acc;
    q_n      = q;
    m_n      = m;
    opr_n    = opr;
    count_n  = count;
    result_n = result;
    div0_n   = div0;
    c        = 1'b0;
    s        = acc;
    qb       = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          acc_n   = '0;
          q_n     = a;
          m_n     = b;
          opr_n   = op;
          count_n = '0;
          state_n = ST_RUN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (opr == OP_MUL) begin
          c     = q[0] & as_co;
          s     = q[0] ? as_r : acc;
          acc_n = {c, s[W-1:1]};
          q_n   = {s[0], q[W-1:1]};
        end else begin
          // A set top bit of the shifted remainder always exceeds m.
          qb    = acc[W-1] | as_co;
          acc_n = qb ? as_r : as_x;
          q_n   = {q[W-2:0], qb};
        end
        count_n = count + CW'(1);
        if (count == CW'(W-1)) begin
          state_n  = ST_DONE;
          result_n = {acc_n, q_n};
          div0_n   = (opr == OP_DIV) && (m == '0);
        end
      end
      default: state_n = ST_IDLE;
    endcase

    busy_n = (state_n == ST_RUN);
    done_n = (state_n == ST_DONE);
  end

endmodule

// File: tb/tb_muldiv4_seq.sv
// Self-checking bench for muldiv4_seq against an arithmetic reference model.
module tb_muldiv4_seq;

  logic       clk, rst, start, op, busy, done, div0;
  logic [3:0] a, b;
  logic [7:0] result;

  int pass_cnt = 0;
  int total    = 0;

  muldiv4_seq #(.W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .div0   (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {div0, result} from plain arithmetic.
  function automatic logic [8:0] model(input logic o, input logic [3:0] av, input logic [3:0] bv);
    logic [7:0] p;
    if (o == 1'b0) begin
      p = 8'(av) * 8'(bv);
      return {1'b0, p};
    end
    if (bv == 4'd0) return {1'b1, av, 4'hF};
    return {1'b0, 4'(av % bv), 4'(av / bv)};
  endfunction

  // Issue one operation and wait (bounded) for done.
  task automatic run_op(input logic o, input logic [3:0] av, input logic [3:0] bv,
                        output logic [7:0] res, output logic d0, output int lat,
                        output logic busy_bad);
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); a = 4'($urandom); b = 4'($urandom);
    lat = 1; busy_bad = 1'b0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy !== 1'b1) busy_bad = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b0) busy_bad = 1'b1;
    res = result; d0 = div0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = 4'd0; b = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    total++; if ({busy, done, div0, result} !== 11'd0) $display("FAIL reset_outputs: got busy=%b done=%b div0=%b result=%h, want all 0", busy, done, div0, result); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({busy, done} !== 2'b00) $display("FAIL idle_quiet: got busy=%b done=%b, want 0 0", busy, done); else pass_cnt++;
  endtask

  task automatic test_fixed(input string name, input logic o, input logic [3:0] av, input logic [3:0] bv);
    logic [7:0] res; logic d0, bb; int lat; logic [8:0] exp;
    exp = model(o, av, bv);
    run_op(o, av, bv, res, d0, lat, bb);
    total++; if (res !== exp[7:0]) $display("FAIL %s_result: got %h, want %h", name, res, exp[7:0]); else pass_cnt++;
    total++; if (d0 !== exp[8]) $display("FAIL %s_div0: got %b, want %b", name, d0, exp[8]); else pass_cnt++;
    total++; if (lat != 5) $display("FAIL %s_latency: got %0d, want 5", name, lat); else pass_cnt++;
    total++; if (bb !== 1'b0) $display("FAIL %s_busy: busy wrong during run or at done", name); else pass_cnt++;
    // done is a single-cycle pulse and the result holds afterwards.
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || result !== exp[7:0] || div0 !== exp[8]) $display("FAIL %s_hold: got done=%b result=%h div0=%b, want 0 %h %b", name, done, result, div0, exp[7:0], exp[8]); else pass_cnt++;
  endtask

  task automatic test_mul();
    test_fixed("mul_13x11", 1'b0, 4'd13, 4'd11);
    test_fixed("mul_15x15", 1'b0, 4'd15, 4'd15);
    test_fixed("mul_0x9",   1'b0, 4'd0,  4'd9);
  endtask

  task automatic test_div();
    test_fixed("div_13_3", 1'b1, 4'd13, 4'd3);
    test_fixed("div_15_1", 1'b1, 4'd15, 4'd1);
    test_fixed("div_7_0",  1'b1, 4'd7,  4'd0);
    test_fixed("div_9_2",  1'b1, 4'd9,  4'd2);
  endtask

  task automatic test_ignore_start();
    int lat;
    start = 1'b1; op = 1'b0; a = 4'd13; b = 4'd11;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      if (lat == 2) begin start = 1'b1; op = 1'b0; a = 4'd1; b = 4'd1; end
      else start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    total++; if (result !== 8'h8F) $display("FAIL ignore_start_result: got %h, want 8f", result); else pass_cnt++;
    total++; if (lat != 5) $display("FAIL ignore_start_latency: got %0d, want 5", lat); else pass_cnt++;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL ignore_start_queued: got busy=%b done=%b, want 0 0", busy, done); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] res; logic d0, bb; int lat;
    run_op(1'b0, 4'd13, 4'd11, res, d0, lat, bb);
    total++; if (res !== 8'h8F) $display("FAIL b2b_first: got %h, want 8f", res); else pass_cnt++;
    // Still in the done cycle: the next start is accepted immediately.
    run_op(1'b0, 4'd2, 4'd3, res, d0, lat, bb);
    total++; if (res !== 8'h06) $display("FAIL b2b_second_result: got %h, want 06", res); else pass_cnt++;
    total++; if (lat != 5) $display("FAIL b2b_second_latency: got %0d, want 5", lat); else pass_cnt++;
    total++; if (bb !== 1'b0) $display("FAIL b2b_second_busy: busy wrong during run or at done"); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] res; logic d0, bb, seen; int lat;
    start = 1'b1; op = 1'b0; a = 4'd15; b = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({busy, done, div0, result} !== 11'd0) $display("FAIL midrun_reset: got busy=%b done=%b div0=%b result=%h, want all 0", busy, done, div0, result); else pass_cnt++;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL midrun_no_done: got activity after reset, want none"); else pass_cnt++;
    run_op(1'b1, 4'd13, 4'd3, res, d0, lat, bb);
    total++; if (res !== 8'h14 || lat != 5) $display("FAIL midrun_fresh: got result=%h lat=%0d, want 14 5", res, lat); else pass_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [7:0] res; logic d0, bb; int lat; logic [8:0] exp;
    logic o; logic [3:0] av, bv;
    for (int i = 0; i < 40; i++) begin
      o  = 1'($urandom);
      av = 4'($urandom);
      bv = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
      exp = model(o, av, bv);
      run_op(o, av, bv, res, d0, lat, bb);
      total++; if ({d0, res} !== exp || lat != 5 || bb !== 1'b0)
        $display("FAIL random_%0d op=%b a=%0d b=%0d: got div0=%b result=%h lat=%0d busy_bad=%b, want %b %h 5 0",
                 i, o, av, bv, d0, res, lat, bb, exp[8], exp[7:0]);
      else pass_cnt++;
      if ($urandom_range(0, 1) == 0) begin @(posedge clk); #1; end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
